shift_issue_queue: RTL and testbench

Upstream issue stage for the 32-bit combinational shifter (operand a, 5-bit amount b, 2-bit type c, result z). It buffers shift commands in a small FIFO and presents the head entry to the shifter. It captures the shifter result into a registered output with a valid/ready handshake. This turns the bare combinational shifter into a flow-controlled pipeline unit.

---
 rtl/shift_issue_queue.sv | 114 +++++++++++
 tb/tb_shift_issue_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_queue.sv
// shift_issue_queue: command FIFO in front of the combinational 32-bit
// shifter, with a registered valid/ready result stage.
// Optional build macro SHIFT_Q_STATS_EN adds a saturating done_cnt output
// that counts result handshakes.
module shift_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AMT_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [AMT_W-1:0]         in_amt,
    input  logic [1:0]               in_type,
    output logic [DATA_W-1:0]        sh_a,
    output logic [AMT_W-1:0]         sh_b,
    output logic [1:0]               sh_c,
    input  logic [DATA_W-1:0]        sh_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_type,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_Q_STATS_EN
    ,
    output logic [15:0]              done_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AMT_W-1:0]  amt_mem  [DEPTH];
    logic [1:0]        type_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              push;
    logic              pop;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = !empty & (!out_valid | out_ready);

    // Command storage: written on push, never reset (pointers/count gate validity)
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_data;
            amt_mem[wr_ptr]  <= in_amt;
            type_mem[wr_ptr] <= in_type;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Present the head command to the shifter, zeroed while the queue is empty
    always_comb begin
        sh_a = '0;
        sh_b = '0;
        sh_c = '0;
        if (!empty) begin
            sh_a = data_mem[rd_ptr];
            sh_b = amt_mem[rd_ptr];
            sh_c = type_mem[rd_ptr];
        end
    end

    // Result register: capture shifter output on pop, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_type  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= sh_z;
            out_type  <= sh_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_Q_STATS_EN
    // Saturating count of completed result handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready && (done_cnt != '1)) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_issue_queue.sv
// tb_shift_issue_queue: directed-vector bench for shift_issue_queue with a
// behavioural shifter model closing the sh_* loop.
// Type encoding used by the model: 00 SLL, 01 SRL, 10 ROL, 11 SRA.
module tb_shift_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_type;
    logic [31:0] sh_a;
    logic [4:0]  sh_b;
    logic [1:0]  sh_c;
    logic [31:0] sh_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_type;
    logic [2:0]  count;
`ifdef SHIFT_Q_STATS_EN
    logic [15:0] done_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    shift_issue_queue #(.DEPTH(4), .DATA_W(32), .AMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_type   (in_type),
        .sh_a      (sh_a),
        .sh_b      (sh_b),
        .sh_c      (sh_c),
        .sh_z      (sh_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_type  (out_type),
        .count     (count)
`ifdef SHIFT_Q_STATS_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference combinational shifter
    always_comb begin
        case (sh_c)
            2'b00:   sh_z = sh_a << sh_b;
            2'b01:   sh_z = sh_a >> sh_b;
            2'b10:   sh_z = (sh_a << sh_b) | (sh_a >> (6'd32 - {1'b0, sh_b}));
            default: sh_z = 32'($signed(sh_a) >>> sh_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_type  = t;
    endtask

    logic [31:0] bp_exp [6] = '{32'h22, 32'h88, 32'h198, 32'h440, 32'hAA0, 32'h1980};

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_type",  32'(out_type), 32'd0);
        check("rst_count",     32'(count), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_sh_a",      sh_a, 32'd0);
        rst_n = 1'b1;

        // Single op
        out_ready = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 5'd4, 2'b00);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        check("single_count1",  32'(count), 32'd1);
        check("single_sh_a",    sh_a, 32'hA5A5A5A5);
        check("single_sh_b",    32'(sh_b), 32'd4);
        check("single_nvalid",  32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_valid",   32'(out_valid), 32'd1);
        check("single_data",    out_data, 32'h5A5A5A50);
        check("single_type",    32'(out_type), 32'd0);
        check("single_count0",  32'(count), 32'd0);
        @(negedge clk);
        check("single_drop",    32'(out_valid), 32'd0);
        check("single_hold",    out_data, 32'h5A5A5A50);

        // Back-to-back at full throughput
        drive(1'b1, 32'hF0F0F0F0, 5'd4, 2'b01);
        @(negedge clk);
        drive(1'b1, 32'h80000000, 5'd8, 2'b11);
        @(negedge clk);
        check("b2b_r1", out_data, 32'h0F0F0F0F);
        check("b2b_t1", 32'(out_type), 32'd1);
        drive(1'b1, 32'hFFFFFFFF, 5'd31, 2'b01);
        @(negedge clk);
        check("b2b_r2", out_data, 32'hFF800000);
        check("b2b_t2", 32'(out_type), 32'd3);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        check("b2b_r3", out_data, 32'h00000001);
        check("b2b_t3", 32'(out_type), 32'd1);
        check("b2b_count", 32'(count), 32'd0);
        @(negedge clk);
        check("b2b_drop", 32'(out_valid), 32'd0);

        // Backpressure: six offered, five accepted
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'h11 * i, 5'(i), 2'b00);
            @(negedge clk);
        end
        check("bp_count",   32'(count), 32'd4);
        check("bp_inready", 32'(in_ready), 32'd0);
        check("bp_valid",   32'(out_valid), 32'd1);
        check("bp_held",    out_data, bp_exp[0]);
        @(negedge clk);
        check("bp_stall_data",  out_data, bp_exp[0]);
        check("bp_stall_count", 32'(count), 32'd4);

        // Full with simultaneous pop: no same-cycle bypass
        out_ready = 1'b1;
        check("full_noby", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("full_count3",  32'(count), 32'd3);
        check("full_inready", 32'(in_ready), 32'd1);
        check("bp_r2",        out_data, bp_exp[1]);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        check("full_pushpop", 32'(count), 32'd3);
        check("bp_r3",        out_data, bp_exp[2]);
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            check("bp_drain", out_data, bp_exp[i]);
            check("bp_drain_count", 32'(count), 32'(5 - i));
        end
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 5'd1, 2'b01);
            @(negedge clk);
        end
        drive(1'b0, '0, '0, '0);
        check("mid_count3", 32'(count), 32'd3);
        check("mid_valid",  32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  out_data, 32'd0);
        check("mid_rst_type",  32'(out_type), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_sh_a",  sh_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd0, 2'b00);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  out_data, 32'hDEADBEEF);
        @(negedge clk);

`ifdef SHIFT_Q_STATS_EN
        // Handshake counter and its saturation
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        check("stats_rst", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i), 5'd0, 2'b00);
            @(negedge clk);
        end
        drive(1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("stats_five", 32'(done_cnt), 32'd5);
        force dut.done_cnt = 16'hFFFF;
        #1 release dut.done_cnt;
        drive(1'b1, 32'h1, 5'd0, 2'b00);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("stats_sat", 32'(done_cnt), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
